// File: rtl/cordic_vec.sv
// Iterative vectoring-mode CORDIC: converts signed (x, y) to magnitude and a full-circle
// 16-bit phase word, one transaction at a time over a valid/ready handshake.
module cordic_vec #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned ITERS = 16,
  parameter int unsigned GW    = 19
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] y_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] mag_out,
  output logic [WIDTH-1:0] phase_out
);

  localparam int unsigned ZW = WIDTH + 1;
  localparam int unsigned IW = $clog2(ITERS);
  localparam int unsigned PW = GW + WIDTH + 1;
  localparam logic [WIDTH-1:0] InvGain = 16'h4DBA;

  typedef enum logic [1:0] {StIdle, StIter, StScale, StDone} state_e;

  state_e                 state_q, state_d;
  logic signed [GW-1:0]   x_q, x_d, y_q, y_d;
  logic signed [ZW-1:0]   z_q, z_d;
  logic [IW-1:0]          iter_q, iter_d;
  logic                   base_q, base_d;
  logic                   zero_q, zero_d;
  logic [WIDTH-1:0]       mag_q, mag_d, phase_q, phase_d;

  logic signed [GW-1:0]   x_ext, y_ext, x_sh, y_sh;
  logic signed [ZW-1:0]   atan_z;
  logic signed [PW-1:0]   prod, prod_sh;
  logic [WIDTH-1:0]       mag_sat, phase_sum;
  logic                   unused_z_msb;

  function automatic logic [WIDTH-1:0] atan_lut(input logic [IW-1:0] idx);
    case (idx)
      4'd0:    atan_lut = 16'h2000;
      4'd1:    atan_lut = 16'h12e4;
      4'd2:    atan_lut = 16'h09fb;
      4'd3:    atan_lut = 16'h0511;
      4'd4:    atan_lut = 16'h028b;
      4'd5:    atan_lut = 16'h0146;
      4'd6:    atan_lut = 16'h00a3;
      4'd7:    atan_lut = 16'h0051;
      4'd8:    atan_lut = 16'h0029;
      4'd9:    atan_lut = 16'h0014;
      4'd10:   atan_lut = 16'h000a;
      4'd11:   atan_lut = 16'h0005;
      4'd12:   atan_lut = 16'h0003;
      4'd13:   atan_lut = 16'h0001;
      4'd14:   atan_lut = 16'h0001;
      default: atan_lut = 16'h0000;
    endcase
  endfunction

  assign x_ext  = {{(GW-WIDTH){x_in[WIDTH-1]}}, x_in};
  assign y_ext  = {{(GW-WIDTH){y_in[WIDTH-1]}}, y_in};
  assign x_sh   = x_q >>> iter_q;
  assign y_sh   = y_q >>> iter_q;
  assign atan_z = {1'b0, atan_lut(iter_q)};

  assign prod    = x_q * $signed({1'b0, InvGain});
  assign prod_sh = prod >>> (WIDTH - 1);

  // Phase is taken modulo 2^WIDTH, so the z sign bit only matters inside the iterations.
  assign phase_sum    = {base_q, {(WIDTH-1){1'b0}}} + z_q[WIDTH-1:0];
  assign unused_z_msb = z_q[ZW-1];

  always_comb begin
    if (prod_sh[PW-1]) begin
      mag_sat = '0;
    end else if (|prod_sh[PW-2:WIDTH]) begin
      mag_sat = '1;
    end else begin
      mag_sat = prod_sh[WIDTH-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    iter_d  = iter_q;
    base_d  = base_q;
    zero_d  = zero_q;
    mag_d   = mag_q;
    phase_d = phase_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          // Fold the left half-plane onto the right so the iterations always converge.
          if (x_ext[GW-1]) begin
            x_d    = -x_ext;
            y_d    = -y_ext;
            base_d = 1'b1;
          end else begin
            x_d    = x_ext;
            y_d    = y_ext;
            base_d = 1'b0;
          end
          z_d     = '0;
          iter_d  = '0;
          zero_d  = (x_in == '0) && (y_in == '0);
          state_d = StIter;
        end
      end
      StIter: begin
        if (!y_q[GW-1]) begin
          x_d = x_q + y_sh;
          y_d = y_q - x_sh;
          z_d = z_q + atan_z;
        end else begin
          x_d = x_q - y_sh;
          y_d = y_q + x_sh;
          z_d = z_q - atan_z;
        end
        iter_d = iter_q + IW'(1);
        if (iter_q == IW'(ITERS - 1)) begin
          state_d = StScale;
        end
      end
      StScale: begin
        mag_d   = zero_q ? '0 : mag_sat;
        phase_d = zero_q ? '0 : phase_sum;
        state_d = StDone;
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      iter_q  <= '0;
      base_q  <= 1'b0;
      zero_q  <= 1'b0;
      mag_q   <= '0;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      iter_q  <= iter_d;
      base_q  <= base_d;
      zero_q  <= zero_d;
      mag_q   <= mag_d;
      phase_q <= phase_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign mag_out   = mag_q;
  assign phase_out = phase_q;

endmodule

// File: tb/tb_cordic_vec.sv
// Scoreboard bench for cordic_vec: directed axis/diagonal/zero/wrap cases with tolerances,
// backpressure and mid-iteration reset, then a random sweep against an integer CORDIC model.
module tb_cordic_vec;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] x_in = '0;
  logic [15:0] y_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] mag_out;
  logic [15:0] phase_out;

  typedef struct {
    int mag;
    int phase;
    int mtol;
    int ptol;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   atan_tab [16] = '{32'h2000, 32'h12e4, 32'h09fb, 32'h0511, 32'h028b, 32'h0146,
                          32'h00a3, 32'h0051, 32'h0029, 32'h0014, 32'h000a, 32'h0005,
                          32'h0003, 32'h0001, 32'h0001, 32'h0000};

  always #5 clk = ~clk;

  cordic_vec #(
    .WIDTH(16),
    .ITERS(16),
    .GW   (19)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x_in     (x_in),
    .y_in     (y_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .mag_out  (mag_out),
    .phase_out(phase_out)
  );

  // wrap folds the difference into a signed 16-bit angle distance.
  task automatic check(input string tag, input int got, input int exp, input int tol,
                       input bit wrap);
    int d;
    logic [15:0] d16;
    d = got - exp;
    if (wrap) begin
      d16 = d[15:0];
      d   = int'($signed(d16));
    end
    n_chk++;
    if (d <= tol && d >= -tol) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (tol %0d)", tag, got, exp, tol);
  endtask

  function automatic exp_t mk(input int mag, input int phase, input int mtol, input int ptol);
    exp_t e;
    e.mag = mag; e.phase = phase; e.mtol = mtol; e.ptol = ptol;
    return e;
  endfunction

  // Bit-level model of the vectoring algorithm with 64-bit accumulators.
  function automatic exp_t model_exp(input logic [15:0] xi, input logic [15:0] yi);
    longint x, y, z, t, m, ph;
    exp_t e;
    x = longint'($signed(xi));
    y = longint'($signed(yi));
    z = 0;
    ph = 0;
    if (x < 0) begin
      x = -x; y = -y; ph = 32768;
    end
    for (int i = 0; i < 16; i++) begin
      if (y >= 0) begin
        t = x + (y >>> i); y = y - (x >>> i); x = t; z = z + atan_tab[i];
      end else begin
        t = x - (y >>> i); y = y + (x >>> i); x = t; z = z - atan_tab[i];
      end
    end
    m = (x * 19898) >>> 15;
    if (m < 0) m = 0;
    if (m > 65535) m = 65535;
    ph = (ph + z) & 64'hFFFF;
    if (xi == 16'h0 && yi == 16'h0) begin
      m = 0; ph = 0;
    end
    e = mk(int'(m), int'(ph), 0, 0);
    return e;
  endfunction

  // Called at a negedge; returns at the negedge right after the accept edge.
  task automatic send(input logic [15:0] x, input logic [15:0] y, input exp_t e);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", int'(in_ready), 1, 0, 1'b0);
    in_valid = 1'b1;
    x_in = x;
    y_in = y;
    @(posedge clk);
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    x_in = 16'($urandom);
    y_in = 16'($urandom);
  endtask

  task automatic collect(input string tag, input bit hold, output exp_t e);
    int lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, 17, 0, 1'b0);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 0, 1, 0, 1'b0);
      e = mk(0, 0, 0, 0);
      return;
    end
    e = sb.pop_front();
    check({tag, "_mag"}, int'(mag_out), e.mag, e.mtol, 1'b0);
    check({tag, "_phase"}, int'(phase_out), e.phase, e.ptol, 1'b1);
    if (!hold) begin
      @(negedge clk);
      check({tag, "_out_valid_clr"}, int'(out_valid), 0, 0, 1'b0);
      check({tag, "_in_ready_back"}, int'(in_ready), 1, 0, 1'b0);
    end
  endtask

  task automatic run(input string tag, input logic [15:0] x, input logic [15:0] y,
                     input exp_t e);
    exp_t got;
    send(x, y, e);
    collect(tag, 1'b0, got);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    logic [15:0] rx, ry;

    repeat (3) @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1, 0, 1'b0);
    check("rst_out_valid", int'(out_valid), 0, 0, 1'b0);
    check("rst_mag", int'(mag_out), 0, 0, 1'b0);
    check("rst_phase", int'(phase_out), 0, 0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    run("ax_px", 16'h4000, 16'h0000, mk(32'h4000, 32'h0000, 8, 4));
    run("ax_py", 16'h0000, 16'h4000, mk(32'h4000, 32'h4000, 8, 4));
    run("ax_nx", 16'hC000, 16'h0000, mk(32'h4000, 32'h8000, 8, 4));
    run("ax_ny", 16'h0000, 16'hC000, mk(32'h4000, 32'hC000, 8, 4));
    run("diag_p", 16'h2D41, 16'h2D41, mk(32'h4000, 32'h2000, 8, 4));
    run("diag_min", 16'h8000, 16'h8000, mk(32'hB505, 32'hA000, 8, 4));
    run("zero", 16'h0000, 16'h0000, mk(0, 0, 0, 0));
    run("wrap_hi", 16'hC000, 16'h0010, mk(32'h4000, 32'h7FF6, 8, 4));
    run("wrap_lo", 16'hC000, 16'hFFF0, mk(32'h4000, 32'h800A, 8, 4));

    // Result must stay put and further requests must be ignored while the consumer stalls.
    out_ready = 1'b0;
    send(16'h2D41, 16'hD2BF, mk(32'h4000, 32'hE000, 8, 4));
    collect("bp", 1'b1, e);
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      x_in = 16'($urandom);
      y_in = 16'($urandom);
      @(negedge clk);
      check("bp_out_valid", int'(out_valid), 1, 0, 1'b0);
      check("bp_in_ready", int'(in_ready), 0, 0, 1'b0);
      check("bp_mag_stable", int'(mag_out), e.mag, e.mtol, 1'b0);
      check("bp_phase_stable", int'(phase_out), e.phase, e.ptol, 1'b1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_out_valid", int'(out_valid), 0, 0, 1'b0);
    check("bp_release_in_ready", int'(in_ready), 1, 0, 1'b0);
    repeat (25) @(negedge clk);
    check("bp_no_ghost", int'(out_valid), 0, 0, 1'b0);

    // Abort in the middle of the iterations.
    send(16'h1234, 16'h0567, model_exp(16'h1234, 16'h0567));
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", int'(in_ready), 1, 0, 1'b0);
    check("mid_rst_out_valid", int'(out_valid), 0, 0, 1'b0);
    check("mid_rst_mag", int'(mag_out), 0, 0, 1'b0);
    check("mid_rst_phase", int'(phase_out), 0, 0, 1'b0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("mid_rst_no_result", int'(out_valid), 0, 0, 1'b0);
    run("post_rst", 16'h4000, 16'h4000, mk(32'h5A82, 32'h2000, 8, 4));

    // Back-to-back with out_ready held high, exact against the model.
    for (int i = 0; i < 1000; i++) begin
      rx = 16'($urandom);
      ry = 16'($urandom);
      if (i == 0) begin rx = 16'h8000; ry = 16'h7FFF; end
      if (i == 1) begin rx = 16'h7FFF; ry = 16'h8000; end
      if (i == 2) begin rx = 16'hFFFF; ry = 16'h0001; end
      run("rnd", rx, ry, model_exp(rx, ry));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
